// File: rtl/multicycle_pkg.sv
// Shared definitions for the multicycle controller: FSM states, opcodes,
// ALU operation codes and the per-phase control bundles.
package multicycle_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [3:0] CC_AND  = 4'b0000;
  localparam logic [3:0] CC_OR   = 4'b0001;
  localparam logic [3:0] CC_ADD  = 4'b0010;
  localparam logic [3:0] CC_XOR  = 4'b0011;
  localparam logic [3:0] CC_SLL  = 4'b0100;
  localparam logic [3:0] CC_SRL  = 4'b0101;
  localparam logic [3:0] CC_SUB  = 4'b0110;
  localparam logic [3:0] CC_SRA  = 4'b0111;
  localparam logic [3:0] CC_SLT  = 4'b1000;
  localparam logic [3:0] CC_SLTU = 4'b1001;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic reg_to_mem;
    logic alu_src;
    logic mem_write;
    logic mem_read;
    logic con_beq;
    logic con_bnq;
    logic con_blt;
    logic con_bgt;
    logic con_jalr;
    logic jal;
    logic auipc;
    logic lui;
    logic pc_write;
  } ctrl_t;

  function automatic logic uses_alu(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_BRANCH) ||
           (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  // Controls driven during EXEC; branches and jumps retire here.
  function automatic ctrl_t exec_ctrl(input logic [6:0] op, input logic [2:0] funct3);
    ctrl_t c;
    c = '0;
    case (op)
      OP_I, OP_LOAD, OP_STORE: c.alu_src = 1'b1;
      OP_BRANCH: begin
        c.pc_write = 1'b1;
        case (funct3)
          3'b000:  c.con_beq = 1'b1;
          3'b001:  c.con_bnq = 1'b1;
          3'b100:  c.con_blt = 1'b1;
          3'b101:  c.con_bgt = 1'b1;
          default: c.pc_write = 1'b0;
        endcase
      end
      OP_JAL:  begin c.jal = 1'b1;      c.reg_write = 1'b1; c.pc_write = 1'b1; end
      OP_JALR: begin c.con_jalr = 1'b1; c.reg_write = 1'b1; c.pc_write = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic ctrl_t mem_ctrl(input logic [6:0] op);
    ctrl_t c;
    c = '0;
    c.mem_read   = (op == OP_LOAD);
    c.mem_write  = (op == OP_STORE);
    c.reg_to_mem = (op == OP_STORE);
    return c;
  endfunction

  function automatic ctrl_t wb_ctrl(input logic [6:0] op);
    ctrl_t c;
    c = '0;
    c.reg_write  = 1'b1;
    c.pc_write   = 1'b1;
    c.mem_to_reg = (op == OP_LOAD);
    c.auipc      = (op == OP_AUIPC);
    c.lui        = (op == OP_LUI);
    return c;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decode; valid is low for undecodable
// opcodes and for branches with an unsupported Funct3.
module alu_decoder
  import multicycle_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] Funct3,
  input  logic [6:0] Funct7,
  output logic [3:0] ALU_CC,
  output logic       valid
);

  // Opcode/funct decode to ALU operation and legality
  always_comb begin
    ALU_CC = CC_ADD;
    valid  = 1'b1;
    case (opcode)
      OP_R, OP_I: begin
        case (Funct3)
          3'b000:  ALU_CC = ((opcode == OP_R) && (Funct7 == 7'b0100000)) ? CC_SUB : CC_ADD;
          3'b001:  ALU_CC = CC_SLL;
          3'b010:  ALU_CC = CC_SLT;
          3'b011:  ALU_CC = CC_SLTU;
          3'b100:  ALU_CC = CC_XOR;
          3'b101:  ALU_CC = Funct7[5] ? CC_SRA : CC_SRL;
          3'b110:  ALU_CC = CC_OR;
          3'b111:  ALU_CC = CC_AND;
          default: ALU_CC = CC_ADD;
        endcase
      end
      OP_BRANCH: begin
        ALU_CC = CC_SUB;
        valid  = (Funct3 == 3'b000) || (Funct3 == 3'b001) ||
                 (Funct3 == 3'b100) || (Funct3 == 3'b101);
      end
      OP_LOAD, OP_STORE, OP_JAL, OP_JALR, OP_AUIPC, OP_LUI: ALU_CC = CC_ADD;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle instruction controller: FETCH/DECODE/EXEC/MEM/WB sequencing with
// a sticky TRAP state for undecodable instructions.
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int ALU_CC_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          opcode,
  input  logic [2:0]          Funct3,
  input  logic [6:0]          Funct7,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  output logic                IRWrite,
  output logic                PCWrite,
  output logic                RegWrite,
  output logic                MemtoReg,
  output logic                RegtoMem,
  output logic                ALUsrc,
  output logic                MemWrite,
  output logic                MemRead,
  output logic                Con_beq,
  output logic                Con_bnq,
  output logic                Con_blt,
  output logic                Con_bgt,
  output logic                Con_Jalr,
  output logic                Jal,
  output logic                AUIPC,
  output logic                LUI,
  output logic [ALU_CC_W-1:0] ALU_CC,
  output logic                illegal,
  output logic [2:0]          state_o
);

  state_t              state;
  ctrl_t               ctrl;
  logic [ALU_CC_W-1:0] alu_cc_r;
  logic [3:0]          dec_cc;
  logic                dec_valid;
  logic                store_done;

  alu_decoder u_alu_decoder (
    .opcode (opcode),
    .Funct3 (Funct3),
    .Funct7 (Funct7),
    .ALU_CC (dec_cc),
    .valid  (dec_valid)
  );

  // State register with controls registered for the state being entered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_FETCH;
      ctrl     <= '0;
      alu_cc_r <= '0;
      illegal  <= 1'b0;
    end else begin
      ctrl     <= '0;
      alu_cc_r <= '0;
      case (state)
        S_FETCH: state <= imem_ready ? S_DECODE : S_FETCH;
        S_DECODE: begin
          if (dec_valid) begin
            state <= S_EXEC;
            ctrl  <= exec_ctrl(opcode, Funct3);
            if (uses_alu(opcode)) alu_cc_r <= ALU_CC_W'(dec_cc);
          end else begin
            state   <= S_TRAP;
            illegal <= 1'b1;
          end
        end
        S_EXEC: begin
          if ((opcode == OP_LOAD) || (opcode == OP_STORE)) begin
            state <= S_MEM;
            ctrl  <= mem_ctrl(opcode);
          end else if ((opcode == OP_BRANCH) || (opcode == OP_JAL) || (opcode == OP_JALR)) begin
            state <= S_FETCH;
          end else begin
            state <= S_WB;
            ctrl  <= wb_ctrl(opcode);
          end
        end
        S_MEM: begin
          if (!dmem_ready) begin
            state <= S_MEM;
            ctrl  <= mem_ctrl(opcode);
          end else if (opcode == OP_LOAD) begin
            state <= S_WB;
            ctrl  <= wb_ctrl(opcode);
          end else begin
            state <= S_FETCH;
          end
        end
        S_WB:    state <= S_FETCH;
        S_TRAP:  state <= S_TRAP;
        default: state <= S_FETCH;
      endcase
    end
  end

  // Handshake-completion strobes must act in the same cycle as the ready input
  assign store_done = (state == S_MEM) && (opcode == OP_STORE) && dmem_ready;
  assign IRWrite    = reset && (state == S_FETCH) && imem_ready;
  assign PCWrite    = ctrl.pc_write | store_done;

  assign RegWrite = ctrl.reg_write;
  assign MemtoReg = ctrl.mem_to_reg;
  assign RegtoMem = ctrl.reg_to_mem;
  assign ALUsrc   = ctrl.alu_src;
  assign MemWrite = ctrl.mem_write;
  assign MemRead  = ctrl.mem_read;
  assign Con_beq  = ctrl.con_beq;
  assign Con_bnq  = ctrl.con_bnq;
  assign Con_blt  = ctrl.con_blt;
  assign Con_bgt  = ctrl.con_bgt;
  assign Con_Jalr = ctrl.con_jalr;
  assign Jal      = ctrl.jal;
  assign AUIPC    = ctrl.auipc;
  assign LUI      = ctrl.lui;
  assign ALU_CC   = alu_cc_r;
  assign state_o  = state;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have parameter ALU_CC_W, default 4, the width of the ALU control code.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have inputs opcode [6:0], Funct3 [2:0] and Funct7 [6:0]: fields of the latched instruction.
REQ-005 The block SHALL have input imem_ready, 1 bit: the instruction word is valid this cycle.
REQ-006 The block SHALL have input dmem_ready, 1 bit: the data memory access completes this cycle.
REQ-007 The block SHALL have output IRWrite, 1 bit: latch the instruction register.
REQ-008 The block SHALL have output PCWrite, 1 bit: update the program counter.
REQ-009 The block SHALL have outputs RegWrite, MemtoReg, RegtoMem, ALUsrc, MemWrite and MemRead, 1 bit each: datapath controls.
REQ-010 The block SHALL have outputs Con_beq, Con_bnq, Con_blt, Con_bgt, Con_Jalr, Jal, AUIPC and LUI, 1 bit each: datapath controls.
REQ-011 The block SHALL have output ALU_CC, ALU_CC_W bits: the ALU operation code.
REQ-012 The block SHALL have output illegal, 1 bit: sticky flag for an undecoded opcode.
REQ-013 The block SHALL have output state_o [2:0]: the current state, for debug.

Function
REQ-014 The FSM SHALL have the states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4 and TRAP=5.
REQ-015 FETCH: the FSM SHALL hold while imem_ready=0; when imem_ready=1 it SHALL assert IRWrite for exactly one cycle and go to DECODE.
REQ-016 DECODE: an opcode outside {0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0010111, 0110111} SHALL go to TRAP; every other opcode SHALL go to EXEC.
REQ-017 EXEC for a branch (1100011) SHALL drive Con_beq (Funct3=000), Con_bnq (001), Con_blt (100) or Con_bgt (101) with ALU_CC=SUB.
REQ-018 EXEC for a branch SHALL then assert PCWrite for that cycle and go to FETCH (3-cycle instruction).
REQ-019 A branch with any other Funct3 SHALL go to TRAP.
REQ-020 EXEC for JAL/JALR SHALL assert Jal or Con_Jalr with RegWrite and PCWrite in that same cycle, then go to FETCH (3 cycles).
REQ-021 EXEC for load/store SHALL drive ALUsrc=1 and ALU_CC=ADD, then go to MEM.
REQ-022 EXEC for every other legal opcode SHALL go to WB.
REQ-023 MEM SHALL hold MemRead=1 (load) or MemWrite=1 and RegtoMem=1 (store) as long as dmem_ready=0; dmem_req is implied by MemRead|MemWrite.
REQ-024 MEM on dmem_ready=1: a load SHALL go to WB; a store SHALL assert PCWrite and go to FETCH.
REQ-025 WB SHALL assert RegWrite and PCWrite for one cycle and go to FETCH.
REQ-026 WB SHALL add MemtoReg=1 for a load, AUIPC=1 for 0010111 and LUI=1 for 0110111.
REQ-027 ALU_CC decode for R-type: Funct3 000 SHALL give ADD, or SUB when Funct7=0100000.
REQ-028 ALU_CC decode for R-type: Funct3 111 SHALL give AND, 110 OR and 100 XOR.
REQ-029 ALU_CC decode for R-type: Funct3 001 SHALL give SLL, 101 SRL or SRA (SRA when Funct7[5]=1), 010 SLT and 011 SLTU.
REQ-030 I-type ALU decode SHALL be identical to R-type except that Funct3 000 always gives ADD; I-type drives ALUsrc=1.
REQ-031 TRAP SHALL set illegal=1, hold every control output at 0 and stay in TRAP until reset.
REQ-032 Every control output SHALL be 0 in any state or cycle that does not explicitly assert it.
REQ-033 PCWrite SHALL assert exactly once per retired instruction.
REQ-034 Opcode and Funct fields SHALL be sampled only after IRWrite, and SHALL be treated as stable from DECODE through the end of the instruction.
REQ-035 Instruction latencies SHALL be: R/I-type and AUIPC/LUI 4 cycles, store 4, load 5, branch/jump 3, each plus imem and dmem wait cycles.

Reset
REQ-036 Asserting reset (0), at any time including mid-instruction or during a MEM wait, SHALL force state FETCH, illegal=0 and all outputs 0 immediately.
REQ-037 The first imem_ready sample after deassertion SHALL occur on the first rising edge with reset=1.

Structure
REQ-038 A package multicycle_pkg SHALL hold the state enum, the opcode constants and the ALU_CC constants.
REQ-039 The ALU_CC constants SHALL be AND=0000, OR=0001, ADD=0010, XOR=0011, SLL=0100, SRL=0101, SUB=0110, SRA=0111, SLT=1000, SLTU=1001.
REQ-040 The ALU_CC decode SHALL be a combinational sub-module alu_decoder (opcode, Funct3, Funct7 -> ALU_CC, valid).
REQ-041 The state register and output logic SHALL reside in multicycle_ctrl.

Verification
REQ-042 add (opcode 0110011, Funct3 000, Funct7 0), imem_ready=1 -> states 0,1,2,4; IRWrite in cycle 1; RegWrite and PCWrite in cycle 4; ALU_CC=0010.
REQ-043 lw with dmem_ready low for 3 cycles -> MEM held 4 cycles with MemRead=1, then WB with MemtoReg=1; 8 cycles total.
REQ-044 beq then bne -> 3 cycles each; Con_beq then Con_bnq asserted in EXEC with ALU_CC=0110.
REQ-045 Opcode 1111111 -> TRAP, illegal=1, no PCWrite; reset low -> FETCH, illegal=0.
REQ-046 sw, reset pulsed during MEM wait -> MemWrite drops at once; first PCWrite only after the next full instruction.
REQ-047 srai (0010011, Funct3 101, Funct7 0100000) -> ALU_CC=0111, ALUsrc=1.
